// File: rtl/ml_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ml_accel_pkg
// Description : Shared types and constants for the accelerator host-readback
//               path (RAM-to-UART dumper and its byte transmitter).
//               Macro DUMP_CHECKSUM_EN adds the CSUM state.
// Revision    : 1.0 - initial release
// ============================================================================
package ml_accel_pkg;

    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        SEND    = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5
`ifdef DUMP_CHECKSUM_EN
        ,
        CSUM    = 3'd6
`endif
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : Bit-serial 8N1 UART transmitter, LSB first. A byte presented
//               with tx_load while idle is framed as start(0), 8 data bits,
//               stop(1); each bit is held for CLKS_PER_BIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import ml_accel_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int            c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    c_LAST_BIT = 4'(UART_FRAME_BITS - 1);

    logic               r_active;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit_idx;
    logic [8:0]         r_shift;   // bits still to send after the current one
    logic               r_tx;

    logic w_bit_end;

    assign w_bit_end = r_active && (r_cnt == c_CNT_MAX);
    // Asserted during the final cycle of the stop bit so the sequencer can
    // react on the very edge the line returns to idle.
    assign tx_done   = w_bit_end && (r_bit_idx == c_LAST_BIT);
    assign tx_busy   = r_active;
    assign tx        = r_tx;

    // Baud counter, bit index and shift register; tx forced high on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '1;
            r_tx      <= 1'b1;
        end else if (!r_active) begin
            if (tx_load) begin
                r_active  <= 1'b1;
                r_cnt     <= '0;
                r_bit_idx <= '0;
                r_shift   <= {1'b1, tx_byte};
                r_tx      <= 1'b0;
            end
        end else if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == c_LAST_BIT) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_bit_idx <= r_bit_idx + 4'd1;
                r_tx      <= r_shift[0];
                r_shift   <= {1'b1, r_shift[8:1]};
            end
        end else begin
            r_cnt <= r_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : ram_uart_dumper
// Description : Host-readback path. Reads `length` bytes from a read-only RAM
//               port starting at base_addr (wrapping modulo the RAM depth)
//               and streams each byte out over an 8N1 UART.
//               Optional macro DUMP_CHECKSUM_EN appends one frame holding the
//               mod-256 sum of all sent bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_uart_dumper
    import ml_accel_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  tx
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    dump_state_t r_state;
    dump_state_t w_next;

    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_done;

    logic                  w_tx_load;
    logic [7:0]            w_tx_byte;
    logic                  w_tx_busy;
    logic                  w_tx_done;

`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            r_sum;
    logic                  r_csum_sent;
`endif

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign ram_addr = r_ram_addr;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .tx_load(w_tx_load),
        .tx_byte(w_tx_byte),
        .tx     (tx),
        .tx_busy(w_tx_busy),
        .tx_done(w_tx_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and transmitter load strobe.
    always_comb begin
        w_next    = r_state;
        w_tx_load = 1'b0;
        w_tx_byte = ram_rdata[7:0];
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (length == '0) ? DONE : RD_ADDR;
                end
            end
            RD_ADDR: begin
                w_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (!w_tx_busy) begin
                    w_tx_load = 1'b1;
                    w_next    = SEND;
                end
            end
            SEND: begin
                if (w_tx_done) begin
                    w_next = NEXT;
                end
            end
            NEXT: begin
                if (r_remaining == '0) begin
`ifdef DUMP_CHECKSUM_EN
                    w_next = r_csum_sent ? DONE : CSUM;
`else
                    w_next = DONE;
`endif
                end else begin
                    w_next = RD_ADDR;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                w_tx_byte = r_sum;
                if (!w_tx_busy) begin
                    w_tx_load = 1'b1;
                    w_next    = SEND;
                end
            end
`endif
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address/count bookkeeping, RAM address register and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q    <= '0;
            r_remaining <= '0;
            r_ram_addr  <= '0;
            r_done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_sum       <= '0;
            r_csum_sent <= 1'b0;
`endif
        end else begin
            // Registered so done lands in the cycle busy drops.
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr_q    <= base_addr;
                        r_remaining <= length;
                        if (length != '0) begin
                            r_ram_addr <= base_addr;
                        end
`ifdef DUMP_CHECKSUM_EN
                        r_sum       <= '0;
                        r_csum_sent <= 1'b0;
`endif
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                RD_WAIT: begin
                    if (w_tx_load) begin
                        r_sum <= r_sum + ram_rdata[7:0];
                    end
                end
                CSUM: begin
                    if (w_tx_load) begin
                        r_csum_sent <= 1'b1;
                    end
                end
`endif
                SEND: begin
                    // The checksum frame also passes through SEND with
                    // nothing left to count, hence the guard.
                    if (w_tx_done && (r_remaining != '0)) begin
                        r_remaining <= r_remaining - c_LEN_ONE;
                        r_addr_q    <= r_addr_q + c_ADDR_ONE;
                    end
                end
                NEXT: begin
                    if (r_remaining != '0) begin
                        r_ram_addr <= r_addr_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
